// File: rtl/key_debouncer_pkg.sv
// Shared types and 50 MHz timing defaults for the key debouncer.
// Optional auto-repeat is enabled by defining KEY_DEBOUNCER_REPEAT_EN.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } key_state_t;

    localparam int KEY_W             = 4;
    localparam int STABLE_50M        = 500000;
    localparam int REPEAT_DELAY_50M  = 25000000;
    localparam int REPEAT_PERIOD_50M = 5000000;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debouncer_cell.sv
// One key: two-flop synchroniser, stability FSM/counter, optional hold repeat.
// Auto-repeat logic exists only when KEY_DEBOUNCER_REPEAT_EN is defined.
module key_debounce_cell
    import key_pkg::*;
#(
    parameter int STABLE_CYCLES        = STABLE_50M,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_50M
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_sw,
    output logic key_press,
    output logic key_release
);

    localparam int CW = cnt_width(STABLE_CYCLES, REPEAT_DELAY_CYCLES,
                                  REPEAT_PERIOD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1, sync2;
    key_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sw_n, press_n, rel_n, rpt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sw_n    = key_sw;
        press_n = 1'b0;
        rel_n   = 1'b0;
        unique case (state)
            RELEASED: begin
                if (!sync2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_n = PRESSED;
                        sw_n    = 1'b0;
                        press_n = 1'b1;
                    end else begin
                        state_n = PRESS_PENDING;
                        cnt_n   = CW'(1);
                    end
                end
            end
            PRESS_PENDING: begin
                if (sync2) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    sw_n    = 1'b0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (sync2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_n = RELEASED;
                        sw_n    = 1'b1;
                        rel_n   = 1'b1;
                    end else begin
                        state_n = RELEASE_PENDING;
                        cnt_n   = CW'(1);
                    end
                end
            end
            RELEASE_PENDING: begin
                if (!sync2) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                    sw_n    = 1'b1;
                    rel_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = RELEASED;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCER_REPEAT_EN
    logic [CW-1:0] hold, hold_n, lim;
    logic          rep, rep_n;

    // Hold count is zero in every non-PRESSED state, so any entry restarts the delay.
    always_comb begin
        lim    = rep ? CW'(REPEAT_PERIOD_CYCLES - 1) : CW'(REPEAT_DELAY_CYCLES - 1);
        hold_n = '0;
        rep_n  = 1'b0;
        rpt    = 1'b0;
        if (state == PRESSED && !sync2) begin
            if (hold == lim) begin
                rpt   = 1'b1;
                rep_n = 1'b1;
            end else begin
                hold_n = hold + CW'(1);
                rep_n  = rep;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            rep  <= 1'b0;
        end else begin
            hold <= hold_n;
            rep  <= rep_n;
        end
    end
`else
    assign rpt = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_sw      <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            key_sw      <= sw_n;
            key_press   <= press_n | rpt;
            key_release <= rel_n;
        end
    end

endmodule

// File: rtl/key_debouncer.sv
// W independent debounced active-low keys with press/release pulses.
// Define KEY_DEBOUNCER_REPEAT_EN for held-key auto-repeat on key_press.
module key_debouncer
    import key_pkg::*;
#(
    parameter int W                    = KEY_W,
    parameter int STABLE_CYCLES        = STABLE_50M,
    parameter int REPEAT_DELAY_CYCLES  = REPEAT_DELAY_50M,
    parameter int REPEAT_PERIOD_CYCLES = REPEAT_PERIOD_50M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_raw,
    output logic [W-1:0] key_sw,
    output logic [W-1:0] key_press,
    output logic [W-1:0] key_release
);

    for (genvar i = 0; i < W; i++) begin : g_key
        key_debounce_cell #(
            .STABLE_CYCLES       (STABLE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .key_raw    (key_raw[i]),
            .key_sw     (key_sw[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

endmodule
